// File: rtl/iob_cache_axi_rd_arbiter.sv
// rtl/iob_cache_axi_rd_arbiter.sv - round-robin arbiter sharing one AXI4 read channel among cache back-ends
module iob_cache_axi_rd_arbiter #(
    parameter int N_MASTERS  = 2,
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_ID_W   = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [N_MASTERS-1:0]             m_arvalid,
    input  logic [N_MASTERS*AXI_ADDR_W-1:0]  m_araddr,
    input  logic [N_MASTERS*8-1:0]           m_arlen,
    input  logic [N_MASTERS*3-1:0]           m_arsize,
    input  logic [N_MASTERS*2-1:0]           m_arburst,
    input  logic [N_MASTERS*AXI_ID_W-1:0]    m_arid,
    output logic [N_MASTERS-1:0]             m_arready,
    output logic [N_MASTERS-1:0]             m_rvalid,
    output logic [AXI_DATA_W-1:0]            m_rdata,
    output logic [1:0]                       m_rresp,
    output logic                             m_rlast,
    input  logic [N_MASTERS-1:0]             m_rready,
    output logic                             s_arvalid,
    output logic [AXI_ADDR_W-1:0]            s_araddr,
    output logic [7:0]                       s_arlen,
    output logic [2:0]                       s_arsize,
    output logic [1:0]                       s_arburst,
    output logic [AXI_ID_W-1:0]              s_arid,
    output logic                             s_arlock,
    output logic [3:0]                       s_arcache,
    output logic [2:0]                       s_arprot,
    output logic [3:0]                       s_arqos,
    input  logic                             s_arready,
    input  logic                             s_rvalid,
    input  logic [AXI_DATA_W-1:0]            s_rdata,
    input  logic [1:0]                       s_rresp,
    input  logic                             s_rlast,
    output logic                             s_rready,
    output logic [N_MASTERS-1:0]             grant,
    output logic                             err
);

    localparam int IDX_W = $clog2(N_MASTERS);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] rr_ptr_next;
    logic [7:0]       len_reg;
    logic [8:0]       beat_cnt;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             ar_hs;
    logic             r_hs;

    assign s_arlock  = 1'b0;
    assign s_arcache = 4'b0011;
    assign s_arprot  = 3'b000;
    assign s_arqos   = 4'b0000;

    // First requester at or after rr_ptr, wrapping around the master set
    always_comb begin
        int idx;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_MASTERS) idx = idx - N_MASTERS;
            if (!pick_found && m_arvalid[idx]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(idx);
            end
        end
    end

    assign rr_ptr_next = (grant_idx == IDX_W'(N_MASTERS - 1)) ? '0 : grant_idx + 1'b1;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next state and channel routing; only the granted master sees handshakes
    always_comb begin
        state_next = state;
        s_arvalid  = 1'b0;
        s_araddr   = '0;
        s_arlen    = '0;
        s_arsize   = '0;
        s_arburst  = '0;
        s_arid     = '0;
        m_arready  = '0;
        m_rvalid   = '0;
        m_rdata    = '0;
        m_rresp    = '0;
        m_rlast    = 1'b0;
        s_rready   = 1'b0;
        ar_hs      = 1'b0;
        r_hs       = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) state_next = ADDR;
            end
            ADDR: begin
                s_arvalid = 1'b1;
                s_araddr  = m_araddr[grant_idx*AXI_ADDR_W +: AXI_ADDR_W];
                s_arlen   = m_arlen[grant_idx*8 +: 8];
                s_arsize  = m_arsize[grant_idx*3 +: 3];
                s_arburst = m_arburst[grant_idx*2 +: 2];
                s_arid    = m_arid[grant_idx*AXI_ID_W +: AXI_ID_W];
                m_arready = grant & {N_MASTERS{s_arready}};
                ar_hs     = s_arready;
                if (s_arready) state_next = DATA;
            end
            DATA: begin
                m_rvalid = grant & {N_MASTERS{s_rvalid}};
                m_rdata  = s_rdata;
                m_rresp  = s_rresp;
                m_rlast  = s_rlast;
                s_rready = m_rready[grant_idx];
                r_hs     = s_rvalid & m_rready[grant_idx];
                if (r_hs && s_rlast) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Grant, round-robin pointer, burst length tracking and sticky error
    always_ff @(posedge clk) begin
        if (!reset) begin
            grant     <= '0;
            grant_idx <= '0;
            rr_ptr    <= '0;
            len_reg   <= '0;
            beat_cnt  <= '0;
            err       <= 1'b0;
        end else begin
            if (state == IDLE && pick_found) begin
                grant           <= '0;
                grant[pick_idx] <= 1'b1;
                grant_idx       <= pick_idx;
            end
            if (ar_hs) begin
                len_reg  <= s_arlen;
                beat_cnt <= '0;
            end
            if (r_hs) begin
                beat_cnt <= beat_cnt + 9'd1;
                if ((s_rlast && beat_cnt != {1'b0, len_reg}) || beat_cnt > {1'b0, len_reg})
                    err <= 1'b1;
                if (s_rlast) begin
                    grant  <= '0;
                    rr_ptr <= rr_ptr_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_iob_cache_axi_rd_arbiter.sv
// tb/tb_iob_cache_axi_rd_arbiter.sv - directed self-checking bench for iob_cache_axi_rd_arbiter
module tb_iob_cache_axi_rd_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  m_arvalid;
    logic [63:0] m_araddr;
    logic [15:0] m_arlen;
    logic [5:0]  m_arsize;
    logic [3:0]  m_arburst;
    logic [1:0]  m_arid;
    logic [1:0]  m_arready;
    logic [1:0]  m_rvalid;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rlast;
    logic [1:0]  m_rready;
    logic        s_arvalid;
    logic [31:0] s_araddr;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;
    logic [1:0]  s_arburst;
    logic [0:0]  s_arid;
    logic        s_arlock;
    logic [3:0]  s_arcache;
    logic [2:0]  s_arprot;
    logic [3:0]  s_arqos;
    logic        s_arready;
    logic        s_rvalid;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    logic        s_rready;
    logic [1:0]  grant;
    logic        err;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_addr [2];
    logic [7:0]  exp_len  [2];

    iob_cache_axi_rd_arbiter #(
        .N_MASTERS(2), .AXI_ADDR_W(32), .AXI_DATA_W(32), .AXI_ID_W(1)
    ) dut (
        .clk(clk), .reset(reset),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arid(m_arid),
        .m_arready(m_arready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rready(m_rready),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arid(s_arid),
        .s_arlock(s_arlock), .s_arcache(s_arcache), .s_arprot(s_arprot),
        .s_arqos(s_arqos), .s_arready(s_arready), .s_rvalid(s_rvalid),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rready(s_rready), .grant(grant), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic request(input int m, input logic [31:0] addr, input logic [7:0] len);
        exp_addr[m]          = addr;
        exp_len[m]           = len;
        m_araddr[m*32 +: 32] = addr;
        m_arlen[m*8 +: 8]    = len;
        m_arsize[m*3 +: 3]   = 3'd2;
        m_arburst[m*2 +: 2]  = 2'b01;
        m_arid[m]            = m[0];
        m_arvalid[m]         = 1'b1;
    endtask

    // Expects IDLE on entry with master m winning the next arbitration
    task automatic do_ar(input int m, input int stall, input bit rearm);
        tick();
        check_eq("ar_grant", grant, 64'(1) << m);
        check_eq("ar_valid", s_arvalid, 1);
        check_eq("ar_addr", s_araddr, exp_addr[m]);
        check_eq("ar_len", s_arlen, exp_len[m]);
        check_eq("ar_id", s_arid, m);
        check_eq("ar_size_burst", {s_arsize, s_arburst}, {3'd2, 2'b01});
        for (int i = 0; i < stall; i++) begin
            check_eq("ar_stall_rdy", m_arready, 0);
            tick();
            check_eq("ar_stall_valid", s_arvalid, 1);
            check_eq("ar_stall_addr", s_araddr, exp_addr[m]);
            check_eq("ar_stall_len", s_arlen, exp_len[m]);
        end
        s_arready = 1'b1;
        #1;
        check_eq("ar_ready", m_arready, 64'(1) << m);
        tick();
        s_arready = 1'b0;
        if (!rearm) m_arvalid[m] = 1'b0;
    endtask

    // Slave returns beats 0..last_beat, rlast on last_beat; ends in IDLE
    task automatic do_data(input int m, input int last_beat, input bit toggle);
        int          b;
        int          cyc;
        logic [31:0] d;
        b   = 0;
        cyc = 0;
        while (b <= last_beat && cyc < 40) begin
            d           = 32'hD000_0000 | (m << 8) | b;
            s_rvalid    = 1'b1;
            s_rdata     = d;
            s_rresp     = 2'b00;
            s_rlast     = (b == last_beat);
            m_rready    = '0;
            m_rready[m] = toggle ? (cyc % 3 != 1) : 1'b1;
            #1;
            check_eq("r_valid", m_rvalid, 64'(1) << m);
            check_eq("r_ready", s_rready, m_rready[m]);
            check_eq("data_ardy", m_arready, 0);
            if (m_rready[m]) begin
                check_eq("r_data", m_rdata, d);
                check_eq("r_last", m_rlast, s_rlast);
            end
            tick();
            if (m_rready[m]) b++;
            cyc++;
        end
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        m_rready = '0;
        check_eq("beats", b, last_beat + 1);
        check_eq("idle_grant", grant, 0);
        check_eq("idle_arvalid", s_arvalid, 0);
    endtask

    initial begin
        reset     = 1'b0;
        m_arvalid = '0;
        m_araddr  = '0;
        m_arlen   = '0;
        m_arsize  = '0;
        m_arburst = '0;
        m_arid    = '0;
        m_rready  = '0;
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        s_rdata   = '0;
        s_rresp   = '0;
        s_rlast   = 1'b0;
        exp_addr  = '{default: '0};
        exp_len   = '{default: '0};
        tick();
        tick();
        check_eq("rst_grant", grant, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_outs", {s_arvalid, s_rready, m_arready, m_rvalid}, 0);
        check_eq("rst_consts", {s_arlock, s_arcache, s_arprot, s_arqos}, {1'b0, 4'b0011, 3'd0, 4'd0});
        reset = 1'b1;

        // single request, one-cycle latency to s_arvalid
        request(0, 32'h1000, 8'd7);
        do_ar(0, 0, 1'b0);
        do_data(0, 7, 1'b0);

        // contention from a fresh pointer: master 0 first, then master 1
        do_reset();
        request(0, 32'h2000, 8'd3);
        request(1, 32'h3000, 8'd3);
        do_ar(0, 0, 1'b0);
        do_data(0, 3, 1'b0);
        do_ar(1, 0, 1'b0);
        do_data(1, 3, 1'b0);

        // fairness: master 0 re-requests immediately, master 1 still gets in
        request(0, 32'h4000, 8'd1);
        do_ar(0, 0, 1'b1);
        request(1, 32'h5000, 8'd1);
        do_data(0, 1, 1'b0);
        do_ar(1, 0, 1'b0);
        do_data(1, 1, 1'b0);
        do_ar(0, 0, 1'b0);
        do_data(0, 1, 1'b0);

        // backpressure on AR and on R
        request(0, 32'h6000, 8'd7);
        do_ar(0, 5, 1'b0);
        do_data(0, 7, 1'b1);
        check_eq("bp_err", err, 0);

        // early rlast sets sticky err
        request(0, 32'h7000, 8'd3);
        do_ar(0, 0, 1'b0);
        do_data(0, 1, 1'b0);
        check_eq("len_err", err, 1);
        request(0, 32'h7100, 8'd3);
        do_ar(0, 0, 1'b0);
        do_data(0, 3, 1'b0);
        check_eq("len_err_sticky", err, 1);

        // reset on beat 2 of 8; pointer currently favours master 1
        request(0, 32'h8000, 8'd7);
        do_ar(0, 0, 1'b0);
        s_rvalid    = 1'b1;
        s_rdata     = 32'hAAAA_0000;
        m_rready[0] = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_eq("mid_rst_grant", grant, 0);
        check_eq("mid_rst_arvalid", s_arvalid, 0);
        check_eq("mid_rst_rready", s_rready, 0);
        check_eq("mid_rst_err", err, 0);
        s_rvalid = 1'b0;
        m_rready = '0;
        reset    = 1'b1;
        request(0, 32'h9000, 8'd0);
        request(1, 32'h9100, 8'd0);
        do_ar(0, 0, 1'b0);
        do_data(0, 0, 1'b0);
        do_ar(1, 0, 1'b0);
        do_data(1, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/iob_cache_axi_rd_arbiter.md
Name: iob_cache_axi_rd_arbiter

Overview:
- Round-robin arbiter that shares one AXI4 read channel (AR + R) between N_MASTERS cache back-ends, e.g. an I-cache and a D-cache, each with a single-outstanding line-fill engine.
- Sits between the cache back-end AXI read ports and the system interconnect/memory controller.
- Allows one outstanding burst at a time. Grant is held from AR acceptance until the R beat carrying rlast completes.
- Checks burst length and reports mismatches on a sticky error flag.

Parameters:
- N_MASTERS, 2, number of requesting masters (2..8).
- AXI_ADDR_W, 32, AXI address width.
- AXI_DATA_W, 32, AXI data width.
- AXI_ID_W, 1, AXI ID width; the ID is passed through unchanged.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset.
- m_arvalid  in  N_MASTERS  per-master AR valid.
- m_araddr  in  N_MASTERS*AXI_ADDR_W  per-master AR address; master i uses slice [i*W +: W] (same slicing for every flattened bus below).
- m_arlen  in  N_MASTERS*8  per-master burst length.
- m_arsize  in  N_MASTERS*3  per-master beat size.
- m_arburst  in  N_MASTERS*2  per-master burst type.
- m_arid  in  N_MASTERS*AXI_ID_W  per-master ID.
- m_arready  out  N_MASTERS  per-master AR ready.
- m_rvalid  out  N_MASTERS  per-master R valid.
- m_rdata  out  AXI_DATA_W  R data, shared by all masters.
- m_rresp  out  2  R response, shared.
- m_rlast  out  1  R last, shared.
- m_rready  in  N_MASTERS  per-master R ready.
- s_arvalid / s_araddr / s_arlen / s_arsize / s_arburst / s_arid  out  1/AXI_ADDR_W/8/3/2/AXI_ID_W  AR channel to the slave.
- s_arlock / s_arcache / s_arprot / s_arqos  out  1/4/3/4  constants 0 / 4'b0011 / 0 / 0.
- s_arready  in  1  slave AR ready.
- s_rvalid / s_rdata / s_rresp / s_rlast  in  1/AXI_DATA_W/2/1  R channel from the slave.
- s_rready  out  1  R ready to the slave.
- grant  out  N_MASTERS  one-hot current owner; all zero in IDLE.
- err  out  1  sticky burst-length mismatch flag.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; grant=0; err=0; beat counter=0.
  - Round-robin pointer set so master 0 has top priority.
  - All outputs 0 except the constant s_arlock/s_arcache/s_arprot/s_arqos.
  - Reset mid-burst abandons the burst; the slave is assumed to be reset together with the arbiter.
- States: IDLE, ADDR, DATA.
- IDLE:
  - If any m_arvalid is set, pick the first requester at or after rr_ptr (wrapping modulo N_MASTERS).
  - Register that pick into grant and go to ADDR.
  - No AR or R handshake is possible in IDLE.
- ADDR:
  - s_arvalid=1; s_ar* fields are muxed combinationally from the granted master's inputs, which AXI rules require to be held stable.
  - m_arready[g]=s_arready; all other m_arready=0.
  - On s_arvalid&s_arready: latch arlen into len_reg, clear the beat counter, go to DATA.
- DATA:
  - m_rvalid[g]=s_rvalid; m_rdata/m_rresp/m_rlast pass through from the slave.
  - s_rready=m_rready[g]; non-granted m_rvalid=0.
  - Each R handshake increments the beat counter (9 bits, so no wrap at 256 beats).
  - On a handshake with s_rlast=1: return to IDLE, set rr_ptr=g+1 (mod N_MASTERS), clear grant.
- Latency: one cycle from m_arvalid rising in IDLE to s_arvalid high. After a burst ends, a new grant is issued one cycle later (IDLE is always visited for one cycle).
- Length check:
  - rlast on a beat whose index != len_reg, or a beat with index > len_reg, sets err=1.
  - err is cleared only by reset.
  - Burst termination is decided only by rlast.
- A master may not drop m_arvalid before its handshake. If it does while in ADDR, the arbiter keeps s_arvalid high (AXI stability rule) and behaviour is that master's fault; this is not checked.
- Simultaneous requests are resolved by rr_ptr. A master requesting again right after its own burst loses to any other waiting master.
- Only one transaction is outstanding, so no ID reordering is needed; s_arid=m_arid[g].

Test Plan:
- Single request: master 0 requests araddr=0x1000, arlen=7. Expect s_arvalid one cycle later with matching fields, eight beats routed only to master 0, m_rvalid[1]=0 throughout, grant=0 one cycle after rlast.
- Contention: masters 0 and 1 request at once with arlen=3 each. Expect grant=01 for master 0's burst, then grant=10, with s_araddr switching accordingly. Master 1 never sees arready during master 0's burst.
- Fairness: master 0 requests back-to-back continuously while master 1 requests once. Expect master 1 served after master 0's current burst, never starved.
- Backpressure: s_arready held 0 for 5 cycles, and m_rready[0] toggled during DATA. Expect AR fields stable throughout, no beat lost or duplicated, and the beat counter equal to 8 at rlast.
- Length error: arlen=3 with slave asserting rlast on the 2nd beat. Expect err=1, return to IDLE, err still 1 after a following good burst.
- Reset mid-burst: assert reset on beat 2 of 8. Expect the next cycle to have grant=0, s_arvalid=0, s_rready=0, err=0, and master 0 winning the first arbitration afterward.
